alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Issue and retire stage that wraps the combinational 32-bit ALU. It buffers incoming operations {A, B, ALUOp} in a small FIFO and presents the head entry to the ALU. It registers Result/Zero/Overflow into an output stage with valid/ready handshaking, and screens out illegal opcodes and divide-by-zero before their results are used.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
WIDTH, 32, operand/result width; must match the ALU
ERRW, 8, width of the saturating error counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream offers an operation
in_ready  output  1  FIFO can accept (= not full)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  4  ALUOp code
alu_a  output  WIDTH  to ALU A
alu_b  output  WIDTH  to ALU B
alu_op  output  4  to ALU ALUOp
alu_result  input  WIDTH  from ALU Result
alu_zero  input  1  from ALU Zero
alu_overflow  input  1  from ALU Overflow
out_valid  output  1  registered result available
out_ready  input  1  downstream accepts the result
out_result  output  WIDTH  registered result
out_zero  output  1  registered Zero flag
out_overflow  output  1  registered Overflow flag
out_op  output  4  opcode that produced the result
out_err  output  1  result is an error substitute
err_count  output  ERRW  saturating count of error results

Behaviour:
- Opcode map, fixed:
  - 0000 add, 0001 sub, 0010 mul, 0011 div
  - 0100 and, 0101 or, 0110 xor
  - 0111 sll, 1000 srl, 1001 sra
  - 1010-1111 are illegal.
- Reset (rst_n low at a clock edge): FIFO emptied (rd/wr pointers 0, count 0).
  - out_valid=0, out_result=0, out_zero=0, out_overflow=0, out_op=0, out_err=0, err_count=0.
  - Reset mid-operation discards all queued and held operations; no partial output survives.
- Push: occurs on in_valid && in_ready at a rising edge.
  - in_ready = (count != DEPTH), derived from registered count only.
  - No same-cycle bypass when full: a pop in the same cycle does not raise in_ready.
- ALU drive: the head entry drives alu_a/alu_b/alu_op combinationally from FIFO storage.
  - When the FIFO is empty, drive alu_a=0, alu_b=0, alu_op=0000.
- Capture/pop: occurs when the FIFO is non-empty and (!out_valid || out_ready).
  - At that edge: pop the head, load the output registers, set out_valid=1.
  - Otherwise, if out_valid && out_ready, clear out_valid.
  - Output registers hold stable while out_valid && !out_ready.
- Normal load: out_result=alu_result, out_zero=alu_zero, out_overflow=alu_overflow, out_op=head op, out_err=0.
- Illegal op load: out_result=0, out_zero=1, out_overflow=0, out_err=1.
- Divide by zero (op 0011 with head B==0): out_result=32'hFFFFFFFF, out_zero=0, out_overflow=0, out_err=1.
- err_count increments on each error load and saturates at all-ones.
- Simultaneous push and pop: count unchanged, and both pointers advance modulo DEPTH.
- Latency: an op pushed at edge k into an empty FIFO with an idle output stage produces out_valid=1 after edge k+1.
- Throughput: 1 op/cycle sustained when out_ready is held high.
- Ordering: strictly FIFO. Outputs retire in acceptance order.

Test Plan:
- Add: in_a=45, in_b=23, op=0000, out_ready=1 -> out_valid one cycle after acceptance, out_result=68, out_zero=0, out_err=0, out_op=0000.
- Backpressure: out_ready=0, push 5 ops (45/23 with ops 0000, 0001, 0100, 0101, 0110).
  - in_ready must drop after the 5th acceptance (1 in output reg + 4 in FIFO), and out_result holds 68.
  - Then raise out_ready -> results 68, 22, 5, 63, 58 in order, one per cycle.
- Div by zero and illegal op: push 45/0 op 0011, then 45/23 op 1100.
  - 1st result: out_result=FFFFFFFF, out_err=1.
  - 2nd result: out_result=0, out_zero=1, out_err=1.
  - err_count=2.
- Shift and divide: A=-45, B=2, op=1001 -> out_result=FFFFFFF4; A=45, B=23, op=0011 -> out_result=1.
- Reset mid-stream: queue 3 ops with out_ready=0, drive rst_n=0 for one edge.
  - Required: out_valid=0, in_ready=1, err_count=0; no stale results after release.
- Saturation: push 300 illegal ops with out_ready=1 -> err_count=255, no wrap.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Upstream operation stream and downstream result stream of the ALU issue stage.
// master = producer/consumer side (testbench or pipeline), slave = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_overflow;
  logic [3:0]       out_op;
  logic             out_err;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_overflow, out_op, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_overflow, out_op, out_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/retire wrapper around a combinational ALU: operation FIFO, head-driven ALU
// inputs, registered result stage with illegal-op / divide-by-zero substitution.
module alu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  io,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic [ERRW-1:0]  err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MAX = 4'b1001;

  logic [WIDTH-1:0] mem_a  [DEPTH];
  logic [WIDTH-1:0] mem_b  [DEPTH];
  logic [3:0]       mem_op [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic             out_zero_q;
  logic             out_overflow_q;
  logic [3:0]       out_op_q;
  logic             out_err_q;
  logic [ERRW-1:0]  err_count_q;

  logic fifo_empty;
  logic push;
  logic pop;
  logic head_illegal;
  logic head_div0;
  logic err_load;

  assign fifo_empty  = (count == '0);
  // in_ready looks only at the registered count, so a full FIFO never admits
  // a push even when a pop happens on the same edge.
  assign io.in_ready = (count != FULL_CNT);
  assign push        = io.in_valid && io.in_ready;
  assign pop         = !fifo_empty && (!out_valid_q || io.out_ready);

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 4'b0000;
    if (!fifo_empty) begin
      alu_a  = mem_a[rd_ptr];
      alu_b  = mem_b[rd_ptr];
      alu_op = mem_op[rd_ptr];
    end
  end

  assign head_illegal = (alu_op > OP_MAX);
  assign head_div0    = (alu_op == OP_DIV) && (alu_b == '0);
  assign err_load     = head_illegal || head_div0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]  <= io.in_a;
      mem_b[wr_ptr]  <= io.in_b;
      mem_op[wr_ptr] <= io.in_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_zero_q     <= 1'b0;
      out_overflow_q <= 1'b0;
      out_op_q       <= 4'b0000;
      out_err_q      <= 1'b0;
      err_count_q    <= '0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_op_q    <= alu_op;
      if (head_illegal) begin
        out_result_q   <= '0;
        out_zero_q     <= 1'b1;
        out_overflow_q <= 1'b0;
        out_err_q      <= 1'b1;
      end else if (head_div0) begin
        out_result_q   <= '1;
        out_zero_q     <= 1'b0;
        out_overflow_q <= 1'b0;
        out_err_q      <= 1'b1;
      end else begin
        out_result_q   <= alu_result;
        out_zero_q     <= alu_zero;
        out_overflow_q <= alu_overflow;
        out_err_q      <= 1'b0;
      end
      if (err_load && (err_count_q != '1)) err_count_q <= err_count_q + ERRW'(1);
    end else if (out_valid_q && io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign io.out_valid    = out_valid_q;
  assign io.out_result   = out_result_q;
  assign io.out_zero     = out_zero_q;
  assign io.out_overflow = out_overflow_q;
  assign io.out_op       = out_op_q;
  assign io.out_err      = out_err_q;
  assign err_count       = err_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: vector table of single ops plus hand-written
// backpressure, error, reset and saturation sequences against a behavioural ALU.
module tb_alu_issue_ctrl;
  localparam int WIDTH = 32;
  localparam int ERRW  = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_overflow;
  logic [ERRW-1:0]  err_count;

  int tests_run;
  int tests_failed;

  alu_issue_ctrl_if #(.WIDTH(WIDTH)) io ();

  alu_issue_ctrl #(.DEPTH(4), .WIDTH(WIDTH), .ERRW(ERRW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .io           (io),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU; illegal and divide-by-zero return junk the DUT must not pass on.
  always_comb begin
    alu_result   = 32'hDEADBEEF;
    alu_overflow = 1'b0;
    case (alu_op)
      4'd0: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      4'd1: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      4'd2: alu_result = alu_a * alu_b;
      4'd3: alu_result = (alu_b != 0) ? (alu_a / alu_b) : 32'h12345678;
      4'd4: alu_result = alu_a & alu_b;
      4'd5: alu_result = alu_a | alu_b;
      4'd6: alu_result = alu_a ^ alu_b;
      4'd7: alu_result = alu_a << alu_b[4:0];
      4'd8: alu_result = alu_a >> alu_b[4:0];
      4'd9: alu_result = $signed(alu_a) >>> alu_b[4:0];
      default: alu_result = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_ovf;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int waited;
    waited = 0;
    while (!io.in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!io.in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL push_timeout: in_ready stuck at %b, need 1", io.in_ready);
    end
    io.in_valid = 1'b1;
    io.in_a     = a;
    io.in_b     = b;
    io.in_op    = op;
    tick();
    io.in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp_exp [5];
    logic [3:0]  bp_ops [5];
    int exp_errcnt;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0]  = '{32'd45,        32'd23, 4'b0000, 32'd68,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'd45,        32'd23, 4'b0001, 32'd22,        1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'd45,        32'd23, 4'b0010, 32'd1035,      1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'd45,        32'd23, 4'b0011, 32'd1,         1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'hFFFFFFD3,  32'd2,  4'b1001, 32'hFFFFFFF4,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'd45,        32'd3,  4'b0111, 32'd360,       1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h80000000,  32'd4,  4'b1000, 32'h08000000,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'd23,        32'd23, 4'b0001, 32'd0,         1'b1, 1'b0, 1'b0};
    vecs[8]  = '{32'h7FFFFFFF,  32'd1,  4'b0000, 32'h80000000,  1'b0, 1'b1, 1'b0};
    vecs[9]  = '{32'h80000000,  32'd1,  4'b0001, 32'h7FFFFFFF,  1'b0, 1'b1, 1'b0};
    vecs[10] = '{32'd7,         32'd0,  4'b0011, 32'hFFFFFFFF,  1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'd9,         32'd9,  4'b1111, 32'd0,         1'b1, 1'b0, 1'b1};

    bp_exp[0] = 32'd68; bp_exp[1] = 32'd22; bp_exp[2] = 32'd5;
    bp_exp[3] = 32'd63; bp_exp[4] = 32'd58;
    bp_ops[0] = 4'b0000; bp_ops[1] = 4'b0001; bp_ops[2] = 4'b0100;
    bp_ops[3] = 4'b0101; bp_ops[4] = 4'b0110;

    io.in_valid  = 1'b0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.in_op     = '0;
    io.out_ready = 1'b1;
    rst_n        = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    check("reset_outputs",
          {io.out_valid, io.out_result, io.out_zero, io.out_overflow, io.out_op, io.out_err},
          {1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0});
    check("reset_in_ready", io.in_ready, 1);
    check("reset_err_count", err_count, 0);
    check("reset_alu_drive", {alu_a, alu_b, alu_op}, 68'h0);

    // Divide-by-zero then illegal, back to back.
    push(32'd45, 32'd0, 4'b0011);
    push(32'd45, 32'd23, 4'b1100);
    check("div0_result",
          {io.out_valid, io.out_result, io.out_zero, io.out_overflow, io.out_op, io.out_err},
          {1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 4'b0011, 1'b1});
    tick();
    check("illegal_result",
          {io.out_valid, io.out_result, io.out_zero, io.out_overflow, io.out_op, io.out_err},
          {1'b1, 32'h0, 1'b1, 1'b0, 4'b1100, 1'b1});
    tick();
    check("err_count_two", err_count, 2);
    exp_errcnt = 2;

    for (int i = 0; i < NVEC; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].op);
      tick();
      check($sformatf("vec%0d", i),
            {io.out_valid, io.out_result, io.out_zero, io.out_overflow, io.out_op, io.out_err},
            {1'b1, vecs[i].exp_result, vecs[i].exp_zero, vecs[i].exp_ovf, vecs[i].op, vecs[i].exp_err});
      if (vecs[i].exp_err) exp_errcnt++;
    end
    tick();
    check("err_count_after_vecs", err_count, exp_errcnt);
    check("idle_after_vecs", io.out_valid, 0);

    // Backpressure: one result held in the output stage plus a full FIFO.
    io.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'd45, 32'd23, bp_ops[i]);
    check("bp_in_ready_low", io.in_ready, 0);
    check("bp_hold", {io.out_valid, io.out_result}, {1'b1, bp_exp[0]});
    tick();
    check("bp_hold_stable", {io.out_valid, io.out_result, io.in_ready}, {1'b1, bp_exp[0], 1'b0});
    io.out_ready = 1'b1;
    #1;
    check("bp_no_bypass", io.in_ready, 0);
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("bp_drain%0d", i),
            {io.out_valid, io.out_result, io.out_op}, {1'b1, bp_exp[i], bp_ops[i]});
    end
    tick();
    check("bp_drained", {io.out_valid, io.in_ready}, 2'b01);

    // Reset with work queued and a result held.
    io.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'd45, 32'd23, 4'b0000);
    pulse_reset();
    check("midrst_state",
          {io.out_valid, io.in_ready, err_count, io.out_result},
          {1'b0, 1'b1, 8'd0, 32'h0});
    io.out_ready = 1'b1;
    repeat (4) tick();
    check("midrst_no_stale", {io.out_valid, alu_op, err_count}, {1'b0, 4'h0, 8'd0});

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) push(32'd1, 32'd2, 4'b1110);
    repeat (3) tick();
    check("err_count_saturated", err_count, 255);
    check("sat_idle", io.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
